onehot_scan_decoder: RTL and testbench

- Parametrised, registered successor to the 2-bit, 4-output cell-select decoder.
- Drives a one-hot select bus of NUM_OUT lines for row/cell addressing in the Life grid datapath.
- Two uses:
  - Direct mode: latch an index, hold its one-hot select.
  - Scan mode: step the select across all outputs under a STEP strobe, with optional wrap-around and a completion pulse.

---
 rtl/onehot_scan_decoder.sv | 116 +++++++++++
 tb/tb_onehot_scan_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot select decoder with direct-load and scan modes; 1-clock command-to-output latency.
// No backpressure: commands are sampled every enabled cycle, ENABLE=0 freezes state and blanks SEL_OUT.
module onehot_scan_decoder #(
  parameter int SEL_WIDTH = 2,
  parameter int NUM_OUT   = 4,
  parameter bit WRAP      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 LOAD,
  input  logic [SEL_WIDTH-1:0] VAL_IN,
  input  logic                 START,
  input  logic                 STEP,
  input  logic                 CLEAR,
  output logic [NUM_OUT-1:0]   SEL_OUT,
  output logic [SEL_WIDTH-1:0] INDEX_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 RANGE_ERR
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_WIDTH:0]   NUM_OUT_L = (SEL_WIDTH+1)'(NUM_OUT);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_OUT - 1);

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   done_d, rerr_d;
  logic [NUM_OUT-1:0]     sel_q, sel_d;
  logic                   busy_q, done_q, rerr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    rerr_d  = 1'b0;
    if (ENABLE) begin
      if (CLEAR) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end else if (START) begin
        idx_d   = '0;
        valid_d = 1'b1;
        state_d = SCAN;
      end else begin
        case (state_q)
          IDLE: begin
            if (LOAD) begin
              if ({1'b0, VAL_IN} < NUM_OUT_L) begin
                idx_d   = VAL_IN;
                valid_d = 1'b1;
              end else begin
                rerr_d = 1'b1;
              end
            end
          end
          SCAN: begin
            if (STEP) begin
              if (idx_q == LAST_IDX) begin
                done_d = 1'b1;
                if (WRAP) begin
                  idx_d = '0;
                end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
                end
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Decode by comparison so out-of-range index values can never light a line.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_d[i] = ENABLE && valid_d && (idx_d == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d == SCAN);
      done_q  <= done_d;
      rerr_q  <= rerr_d;
    end
  end

  assign SEL_OUT   = sel_q;
  assign INDEX_OUT = idx_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RANGE_ERR = rerr_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench: three decoder configurations (default, 5-output, wrapping) share one command stream.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, load, start, step, clear;
  logic [2:0] val;

  logic [3:0] sel0, sel2;
  logic [4:0] sel1;
  logic [1:0] idx0, idx2;
  logic [2:0] idx1;
  logic       busy0, done0, rerr0;
  logic       busy1, done1, rerr1;
  logic       busy2, done2, rerr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_WIDTH(2), .NUM_OUT(4), .WRAP(1'b0)) u_dec4 (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .LOAD(load), .VAL_IN(val[1:0]),
    .START(start), .STEP(step), .CLEAR(clear),
    .SEL_OUT(sel0), .INDEX_OUT(idx0), .BUSY(busy0), .DONE(done0), .RANGE_ERR(rerr0)
  );

  onehot_scan_decoder #(.SEL_WIDTH(3), .NUM_OUT(5), .WRAP(1'b0)) u_dec5 (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .LOAD(load), .VAL_IN(val),
    .START(start), .STEP(step), .CLEAR(clear),
    .SEL_OUT(sel1), .INDEX_OUT(idx1), .BUSY(busy1), .DONE(done1), .RANGE_ERR(rerr1)
  );

  onehot_scan_decoder #(.SEL_WIDTH(2), .NUM_OUT(4), .WRAP(1'b1)) u_dec4w (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .LOAD(load), .VAL_IN(val[1:0]),
    .START(start), .STEP(step), .CLEAR(clear),
    .SEL_OUT(sel2), .INDEX_OUT(idx2), .BUSY(busy2), .DONE(done2), .RANGE_ERR(rerr2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; start = 1'b0; step = 1'b0; clear = 1'b0; val = '0;
    tick();
    tick();
    chk("rst_sel", 32'(sel0), 32'h0);
    chk("rst_idx", 32'(idx0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_rerr", 32'(rerr0), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Direct mode, 4-output truth table delayed by one clock
    load = 1'b1; val = 3'd2;
    tick();
    chk("ld2_sel", 32'(sel0), 32'b0100);
    chk("ld2_idx", 32'(idx0), 32'd2);
    val = 3'd0; tick(); chk("ld0_sel", 32'(sel0), 32'b0001);
    val = 3'd1; tick(); chk("ld1_sel", 32'(sel0), 32'b0010);
    val = 3'd3; tick(); chk("ld3_sel", 32'(sel0), 32'b1000);
    chk("ld3_sel5", 32'(sel1), 32'b01000);

    // 5-output: out-of-range load rejected
    val = 3'd6; tick();
    chk("oor_rerr", 32'(rerr1), 32'h1);
    chk("oor_sel", 32'(sel1), 32'b01000);
    load = 1'b0; tick();
    chk("oor_rerr_pulse", 32'(rerr1), 32'h0);
    chk("oor_sel_hold", 32'(sel1), 32'b01000);
    load = 1'b1; val = 3'd4; tick();
    chk("ld4_sel5", 32'(sel1), 32'b10000);
    chk("ld4_rerr", 32'(rerr1), 32'h0);
    load = 1'b0;

    // Scan: non-wrapping and wrapping instances side by side
    start = 1'b1; tick();
    chk("scan0_sel", 32'(sel0), 32'b0001);
    chk("scan0_busy", 32'(busy0), 32'h1);
    chk("scan0_selw", 32'(sel2), 32'b0001);
    start = 1'b0; step = 1'b1;
    tick(); chk("scan1_sel", 32'(sel0), 32'b0010); chk("scan1_selw", 32'(sel2), 32'b0010);
    tick(); chk("scan2_sel", 32'(sel0), 32'b0100); chk("scan2_done", 32'(done0), 32'h0);
    tick(); chk("scan3_sel", 32'(sel0), 32'b1000); chk("scan3_donew", 32'(done2), 32'h0);
    tick();
    chk("scan_end_sel", 32'(sel0), 32'h0);
    chk("scan_end_done", 32'(done0), 32'h1);
    chk("scan_end_busy", 32'(busy0), 32'h0);
    chk("scan_end_idx", 32'(idx0), 32'd3);
    chk("wrap_sel", 32'(sel2), 32'b0001);
    chk("wrap_done", 32'(done2), 32'h1);
    chk("wrap_busy", 32'(busy2), 32'h1);
    tick();
    chk("post_sel", 32'(sel0), 32'h0);
    chk("post_done", 32'(done0), 32'h0);
    chk("post_idx", 32'(idx0), 32'd3);
    chk("wrap5_sel", 32'(sel2), 32'b0010);
    chk("wrap5_done", 32'(done2), 32'h0);
    chk("wrap5_busy", 32'(busy2), 32'h1);
    step = 1'b0;

    // Freeze mid-scan at index 2, then CLEAR beats START
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; tick(); tick(); step = 1'b0;
    chk("frz_pre_sel", 32'(sel0), 32'b0100);
    enable = 1'b0; step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_sel", 32'(sel0), 32'h0);
      chk("frz_idx", 32'(idx0), 32'd2);
      chk("frz_busy", 32'(busy0), 32'h1);
    end
    enable = 1'b1; step = 1'b0; tick();
    chk("unfrz_sel", 32'(sel0), 32'b0100);
    clear = 1'b1; start = 1'b1; tick();
    chk("clr_sel", 32'(sel0), 32'h0);
    chk("clr_busy", 32'(busy0), 32'h0);
    chk("clr_done", 32'(done0), 32'h0);
    clear = 1'b0; start = 1'b0;

    // Async reset mid-scan at index 1
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    chk("ar_pre_sel", 32'(sel0), 32'b0010);
    #2 rst = 1'b1;
    #1;
    chk("ar_sel", 32'(sel0), 32'h0);
    chk("ar_idx", 32'(idx0), 32'h0);
    chk("ar_busy", 32'(busy0), 32'h0);
    chk("ar_done", 32'(done0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b1; val = 3'd3; tick(); load = 1'b0;
    chk("ar_ld3_sel", 32'(sel0), 32'b1000);
    chk("ar_ld3_busy", 32'(busy0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
